ula_multiciclo: RTL and testbench

//  Multicycle ALU directly downstream of controladorula: consumes its 5-bit op code plus operands, returns a

---
 rtl/ula_multiciclo.sv | 171 +++++++++++++++++
 tb/tb_ula_multiciclo.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: multicycle ALU with 1-cycle logic/arithmetic ops and an iterative 1-bit/cycle shifter.
// start/done handshake with registered result and flags (zero, overflow, invalid).
`default_nettype none

module ula_multiciclo #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [4:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow,
  output logic               invalid,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_XOR  = 5'b00011;
  localparam logic [4:0] OP_NOR  = 5'b00100;
  localparam logic [4:0] OP_SLT  = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SLTU = 5'b00111;
  localparam logic [4:0] OP_SLL  = 5'b01000;
  localparam logic [4:0] OP_SRL  = 5'b01001;
  localparam logic [4:0] OP_SRA  = 5'b01010;
  localparam logic [4:0] OP_SLLV = 5'b01011;
  localparam logic [4:0] OP_SRLV = 5'b01100;
  localparam logic [4:0] OP_SRAV = 5'b01101;

  localparam logic [1:0] SK_LL = 2'd0;
  localparam logic [1:0] SK_RL = 2'd1;
  localparam logic [1:0] SK_RA = 2'd2;

  state_t             state;
  logic [WIDTH-1:0]   shreg;
  logic [SHAMT_W-1:0] cnt;
  logic [1:0]         kind;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic               op_invalid;
  logic               op_shift;
  logic [SHAMT_W-1:0] op_amt;
  logic [1:0]         op_kind;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   shreg_next;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    alu_res    = '0;
    alu_ovf    = 1'b0;
    op_invalid = 1'b0;
    op_shift   = 1'b0;
    op_amt     = a[SHAMT_W-1:0];
    op_kind    = SK_LL;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  begin op_shift = 1'b1; op_amt = shamt; op_kind = SK_LL; end
      OP_SRL:  begin op_shift = 1'b1; op_amt = shamt; op_kind = SK_RL; end
      OP_SRA:  begin op_shift = 1'b1; op_amt = shamt; op_kind = SK_RA; end
      OP_SLLV: begin op_shift = 1'b1; op_kind = SK_LL; end
      OP_SRLV: begin op_shift = 1'b1; op_kind = SK_RL; end
      OP_SRAV: begin op_shift = 1'b1; op_kind = SK_RA; end
      default: op_invalid = 1'b1;
    endcase
  end

  always_comb begin
    shreg_next = {shreg[WIDTH-2:0], 1'b0};
    case (kind)
      SK_RL:   shreg_next = {1'b0, shreg[WIDTH-1:1]};
      SK_RA:   shreg_next = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
      default: shreg_next = {shreg[WIDTH-2:0], 1'b0};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      kind     <= SK_LL;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (op_shift && op_amt != '0) begin
              shreg <= b;
              cnt   <= op_amt;
              kind  <= op_kind;
              state <= SHIFT;
            end else if (op_shift) begin
              result   <= b;
              zero     <= (b == '0);
              overflow <= 1'b0;
              invalid  <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              // Invalid ops fall out of the case with alu_res=0, alu_ovf=0.
              result   <= alu_res;
              zero     <= (alu_res == '0);
              overflow <= alu_ovf;
              invalid  <= op_invalid;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        SHIFT: begin
          shreg <= shreg_next;
          cnt   <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            result   <= shreg_next;
            zero     <= (shreg_next == '0);
            overflow <= 1'b0;
            invalid  <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ula_multiciclo.sv
// Directed self-checking bench for ula_multiciclo: scoreboard of expected completions, immediate assertions.
`default_nettype none

module tb_ula_multiciclo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] result;
  logic        zero, overflow, invalid, busy, done;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        ovf;
    logic        inv;
    int          lat;
  } exp_t;

  exp_t sb[$];

  ula_multiciclo #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .shamt(shamt),
    .result(result), .zero(zero), .overflow(overflow), .invalid(invalid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one op, wait for done, compare against the scoreboard head.
  task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [4:0] sh,
                        input logic [31:0] er, input logic eo, input logic ei, input int el);
    exp_t e;
    int cycles, busy_cnt;
    sb.push_back('{tag, er, eo, ei, el});
    op = o; a = aa; b = bb; shamt = sh; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 5'b11111; a = '1; b = '1; shamt = '1;
    cycles = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (busy) busy_cnt++;
    end
    e = sb.pop_front();
    if (!done) begin
      check({e.tag, " timeout"}, 32'd0, 32'd1);
    end else begin
      check({e.tag, " result"},   result, e.res);
      check({e.tag, " zero"},     {31'd0, zero},     {31'd0, (e.res == 32'd0)});
      check({e.tag, " overflow"}, {31'd0, overflow}, {31'd0, e.ovf});
      check({e.tag, " invalid"},  {31'd0, invalid},  {31'd0, e.inv});
      check({e.tag, " latency"},  cycles,   e.lat);
      check({e.tag, " busy"},     busy_cnt, e.lat);
    end
    @(posedge clk); #1;
    check({e.tag, " done pulse"}, {31'd0, done}, 32'd0);
    check({e.tag, " idle"},       {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int dones;
    repeat (2) @(posedge clk);
    #1;
    check("reset result",   result, 32'd0);
    check("reset flags",    {27'd0, zero, overflow, invalid, busy, done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("ADD ovf",   5'b00010, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b1, 1'b0, 1);
    run_op("SUB zero",  5'b00110, 32'd5, 32'd5, 5'd0, 32'h0, 1'b0, 1'b0, 1);
    run_op("SUB ovf",   5'b00110, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 1'b1, 1'b0, 1);
    run_op("SLT",       5'b00101, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 1'b0, 1'b0, 1);
    run_op("SLTU",      5'b00111, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1'b0, 1'b0, 1);
    run_op("OR",        5'b00001, 32'hF0, 32'h0F, 5'd0, 32'hFF, 1'b0, 1'b0, 1);
    run_op("XOR",       5'b00011, 32'hFF, 32'h0F, 5'd0, 32'hF0, 1'b0, 1'b0, 1);
    run_op("NOR",       5'b00100, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
    run_op("INV 0E",    5'b01110, 32'h12, 32'h34, 5'd0, 32'h0, 1'b0, 1'b1, 1);
    run_op("INV 1F",    5'b11111, 32'h12, 32'h34, 5'd0, 32'h0, 1'b0, 1'b1, 1);
    run_op("SRA 4",     5'b01010, 32'h0, 32'h80000000, 5'd4, 32'hF8000000, 1'b0, 1'b0, 5);
    run_op("SRL 4",     5'b01001, 32'h0, 32'h80000000, 5'd4, 32'h08000000, 1'b0, 1'b0, 5);
    run_op("SLLV 31",   5'b01011, 32'd31, 32'h1, 5'd0, 32'h80000000, 1'b0, 1'b0, 32);
    run_op("SLL 0",     5'b01000, 32'd9, 32'hA5, 5'd0, 32'hA5, 1'b0, 1'b0, 1);
    run_op("SLL 1",     5'b01000, 32'd7, 32'h1, 5'd1, 32'h2, 1'b0, 1'b0, 2);
    run_op("SRLV lo5",  5'b01100, 32'h24, 32'hF0, 5'd0, 32'h0F, 1'b0, 1'b0, 5);
    run_op("SRAV 1",    5'b01101, 32'h1, 32'hFFFFFFFE, 5'd9, 32'hFFFFFFFF, 1'b0, 1'b0, 2);

    // start re-pulsed mid-shift must be ignored
    op = 5'b01001; a = '0; b = 32'h80; shamt = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    op = 5'b00000; a = 32'hF0; b = 32'h3C; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin
        dones++;
        check("ignore result", result, 32'h10);
      end
      @(posedge clk); #1;
    end
    check("ignore single done", dones, 1);

    // async reset in the middle of SRL by 10
    op = 5'b01001; b = 32'hFFFF0000; shamt = 5'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("async rst result", result, 32'd0);
    check("async rst flags",  {27'd0, zero, overflow, invalid, busy, done}, 32'd0);
    dones = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abandoned no done", dones, 0);

    run_op("AND post rst", 5'b00000, 32'hF0, 32'h3C, 5'd0, 32'h30, 1'b0, 1'b0, 1);

    check("scoreboard empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
